// File: rtl/demux2_reg_pkg.sv
// Shared definitions for the demux2_reg stream demultiplexer: default widths, channel
// indices and the slot acceptance rule.
package demux2_reg_pkg;

  localparam int unsigned BW_DATA_DEF = 4;
  localparam int unsigned BW_CNT_DEF  = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // A slot takes a new word when empty, or when its current word leaves this cycle.
  function automatic logic slot_can_accept(input logic full, input logic ready);
    return !full || ready;
  endfunction

endpackage

// File: rtl/demux2_slot.sv
// Single-entry holding register with valid/ready output handshake.
// Optional delivery counter enabled by DEMUX2_REG_CNT_EN.
module demux2_slot
  import demux2_reg_pkg::*;
#(
  parameter int unsigned DataW = BW_DATA_DEF
`ifdef DEMUX2_REG_CNT_EN
  ,
  parameter int unsigned CntW  = BW_CNT_DEF
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  output logic             can_accept_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DataW-1:0] data_o
`ifdef DEMUX2_REG_CNT_EN
  ,
  output logic [CntW-1:0]  cnt_o
`endif
);

  logic             full_q, full_d;
  logic [DataW-1:0] data_q, data_d;
  logic             out_fire;

  assign out_fire     = full_q & ready_i;
  assign can_accept_o = slot_can_accept(full_q, ready_i);
  assign valid_o      = full_q;
  assign data_o       = data_q;

  // A load in the same cycle as a drain keeps the slot full with the new word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

`ifdef DEMUX2_REG_CNT_EN
  logic [CntW-1:0] cnt_q, cnt_d;

  // Wraps naturally at 2^CntW.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

  load_only_when_accepting: assert property (
    @(posedge clk_i) disable iff (!rst_ni) load_i |-> can_accept_o
  );

endmodule

// File: rtl/demux2_reg.sv
// Registered 1-to-2 stream demultiplexer: steers each input word by i_sel into one of two
// one-entry output slots. Define DEMUX2_REG_CNT_EN for per-channel delivery counters.
module demux2_reg
  import demux2_reg_pkg::*;
#(
  parameter int unsigned BW_DATA = BW_DATA_DEF
`ifdef DEMUX2_REG_CNT_EN
  ,
  parameter int unsigned BW_CNT  = BW_CNT_DEF
`endif
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_sel,
  input  logic [BW_DATA-1:0] i_data,
  output logic               o_valid0,
  input  logic               i_ready0,
  output logic [BW_DATA-1:0] o_data0,
  output logic               o_valid1,
  input  logic               i_ready1,
  output logic [BW_DATA-1:0] o_data1
`ifdef DEMUX2_REG_CNT_EN
  ,
  output logic [BW_CNT-1:0]  o_cnt0,
  output logic [BW_CNT-1:0]  o_cnt1
`endif
);

  logic can_accept0, can_accept1;
  logic in_fire, load0, load1;

  // Readiness follows only the addressed slot, so a stalled consumer never blocks the other.
  assign o_ready = (i_sel == CH1) ? can_accept1 : can_accept0;
  assign in_fire = i_valid & o_ready;
  assign load0   = in_fire & (i_sel == CH0);
  assign load1   = in_fire & (i_sel == CH1);

  demux2_slot #(
    .DataW (BW_DATA)
`ifdef DEMUX2_REG_CNT_EN
    ,
    .CntW  (BW_CNT)
`endif
  ) u_slot0 (
    .clk_i        (i_clk),
    .rst_ni       (i_rstn),
    .load_i       (load0),
    .data_i       (i_data),
    .can_accept_o (can_accept0),
    .valid_o      (o_valid0),
    .ready_i      (i_ready0),
    .data_o       (o_data0)
`ifdef DEMUX2_REG_CNT_EN
    ,
    .cnt_o        (o_cnt0)
`endif
  );

  demux2_slot #(
    .DataW (BW_DATA)
`ifdef DEMUX2_REG_CNT_EN
    ,
    .CntW  (BW_CNT)
`endif
  ) u_slot1 (
    .clk_i        (i_clk),
    .rst_ni       (i_rstn),
    .load_i       (load1),
    .data_i       (i_data),
    .can_accept_o (can_accept1),
    .valid_o      (o_valid1),
    .ready_i      (i_ready1),
    .data_o       (o_data1)
`ifdef DEMUX2_REG_CNT_EN
    ,
    .cnt_o        (o_cnt1)
`endif
  );

  single_destination: assert property (
    @(posedge i_clk) disable iff (!i_rstn) !(load0 && load1)
  );

endmodule

// File: tb/tb_demux2_reg.sv
// Scoreboard bench for demux2_reg: stimulus pushes expected words per channel, a monitor
// pops and compares on every output handshake.
module tb_demux2_reg;

  localparam int unsigned W = 4;
`ifdef DEMUX2_REG_CNT_EN
  localparam int unsigned CW = 2;
`endif

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic         i_sel = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_valid0, o_valid1;
  logic         i_ready0 = 1'b1;
  logic         i_ready1 = 1'b1;
  logic [W-1:0] o_data0, o_data1;
`ifdef DEMUX2_REG_CNT_EN
  logic [CW-1:0] o_cnt0, o_cnt1;
`endif

  demux2_reg #(
    .BW_DATA (W)
`ifdef DEMUX2_REG_CNT_EN
    ,
    .BW_CNT  (CW)
`endif
  ) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sel    (i_sel),
    .i_data   (i_data),
    .o_valid0 (o_valid0),
    .i_ready0 (i_ready0),
    .o_data0  (o_data0),
    .o_valid1 (o_valid1),
    .i_ready1 (i_ready1),
    .o_data1  (o_data1)
`ifdef DEMUX2_REG_CNT_EN
    ,
    .o_cnt0   (o_cnt0),
    .o_cnt1   (o_cnt1)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_w0, exp_w1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every output handshake must match the oldest expected word for that channel.
  always @(negedge i_clk) begin
    if (o_valid0 === 1'b1 && i_ready0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        n_total++;
        $display("FAIL ch0 spurious: delivered %0h, expected no word at %0t", o_data0, $time);
      end else begin
        exp_w0 = exp_q0.pop_front();
        check("ch0 data", 32'(o_data0), 32'(exp_w0));
      end
    end
    if (o_valid1 === 1'b1 && i_ready1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        n_total++;
        $display("FAIL ch1 spurious: delivered %0h, expected no word at %0t", o_data1, $time);
      end else begin
        exp_w1 = exp_q1.pop_front();
        check("ch1 data", 32'(o_data1), 32'(exp_w1));
      end
    end
  end

  // Drive one request for a cycle; on expected acceptance the word joins its channel queue.
  task automatic send(input logic sel, input logic [W-1:0] data, input logic r0, input logic r1,
                      input logic exp_rdy);
    @(posedge i_clk);
    #1;
    i_valid  = 1'b1;
    i_sel    = sel;
    i_data   = data;
    i_ready0 = r0;
    i_ready1 = r1;
    @(negedge i_clk);
    check("o_ready", 32'(o_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      if (sel) exp_q1.push_back(data);
      else     exp_q0.push_back(data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a pending request that must be ignored.
    i_valid = 1'b1;
    i_sel   = 1'b0;
    i_data  = 4'hF;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset o_valid0", 32'(o_valid0), 32'h0);
    check("reset o_valid1", 32'(o_valid1), 32'h0);
    check("reset o_data0", 32'(o_data0), 32'h0);
    check("reset o_data1", 32'(o_data1), 32'h0);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("o_ready after reset", 32'(o_ready), 32'h1);

    // Steering with both consumers ready.
    send(1'b0, 4'hA, 1'b1, 1'b1, 1'b1);
    send(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
    idle(1);
    @(negedge i_clk);
    check("steer ch1 valid", 32'(o_valid1), 32'h1);
    check("steer ch0 drained", 32'(o_valid0), 32'h0);
    idle(2);
    check("steer ch1 drained", 32'(o_valid1), 32'h0);

    // Back-pressure isolation: ch0 stalled, ch1 keeps flowing.
    send(1'b0, 4'h3, 1'b0, 1'b1, 1'b1);
    send(1'b0, 4'h4, 1'b0, 1'b1, 1'b0);
    send(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
    send(1'b1, 4'h9, 1'b0, 1'b1, 1'b1);
    idle(1);
    @(negedge i_clk);
    check("hold o_valid0", 32'(o_valid0), 32'h1);
    check("hold o_data0", 32'(o_data0), 32'h3);
    idle(3);
    @(negedge i_clk);
    check("hold later o_data0", 32'(o_data0), 32'h3);
    check("ch1 empty while ch0 held", 32'(o_valid1), 32'h0);
    @(posedge i_clk);
    #1;
    i_ready0 = 1'b1;
    idle(1);
    @(negedge i_clk);
    check("ch0 released", 32'(o_valid0), 32'h0);

    // Pass-through on a draining slot.
    send(1'b0, 4'h1, 1'b0, 1'b1, 1'b1);
    send(1'b0, 4'h2, 1'b1, 1'b1, 1'b1);
    idle(1);
    @(negedge i_clk);
    check("pass o_valid0", 32'(o_valid0), 32'h1);
    check("pass o_data0", 32'(o_data0), 32'h2);
    idle(2);

    // Asynchronous reset while ch1 holds a word.
    send(1'b1, 4'hC, 1'b1, 1'b0, 1'b1);
    idle(1);
    @(negedge i_clk);
    check("pre-reset o_valid1", 32'(o_valid1), 32'h1);
    check("pre-reset o_data1", 32'(o_data1), 32'hC);
    #2;
    i_rstn = 1'b0;
    #1;
    check("async reset o_valid1", 32'(o_valid1), 32'h0);
    check("async reset o_data1", 32'(o_data1), 32'h0);
    exp_q1.delete();
    @(posedge i_clk);
    #1;
    i_ready1 = 1'b1;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    idle(3);
    @(negedge i_clk);
    check("post-reset o_valid1", 32'(o_valid1), 32'h0);

`ifdef DEMUX2_REG_CNT_EN
    // Five ch1 deliveries wrap a 2-bit counter to 1.
    send(1'b1, 4'h1, 1'b1, 1'b1, 1'b1);
    send(1'b1, 4'h2, 1'b1, 1'b1, 1'b1);
    send(1'b1, 4'h3, 1'b1, 1'b1, 1'b1);
    send(1'b1, 4'h4, 1'b1, 1'b1, 1'b1);
    send(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
    idle(3);
    @(negedge i_clk);
    check("o_cnt1 wrapped", 32'(o_cnt1), 32'h1);
    check("o_cnt0", 32'(o_cnt0), 32'h0);
`endif

    idle(2);
    check("ch0 queue drained", exp_q0.size(), 32'h0);
    check("ch1 queue drained", exp_q1.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
